// File: rtl/constants_pkg.sv
// constants_pkg: architectural constants shared by the pipeline front end.
//   INST_LEN         - instruction word width
//   NOP_INST         - canonical RISC-V NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC - PC fetched first after reset unless overridden
package constants_pkg;

    localparam int unsigned INST_LEN = 32;
    localparam logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;

endpackage

// File: rtl/instruction_pkg.sv
// instruction_pkg: types used by the fetch stage.
//   fetch_state_e - S_REQ: issuing/holding a request, S_WAIT: awaiting its response
package instruction_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches one instruction at a time from instruction memory
// and presents it with its PC to decode.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   imem_req_valid/ready/addr      - request channel (valid/ready), word-aligned address
//   imem_rsp_valid/data            - response channel (valid only)
//   stall_dec_in                   - decode did not consume the current output
//   redirect_valid, redirect_pc    - single-cycle PC redirect
//   inst_fetched_out, fetch_valid_out, fetch_pc_out - instruction presented to decode
module fetch_stage
    import constants_pkg::*;
    import instruction_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_LEN-1:0] imem_rsp_data,
    input  logic                stall_dec_in,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [INST_LEN-1:0] inst_fetched_out,
    output logic                fetch_valid_out,
    output logic [ADDR_W-1:0]   fetch_pc_out
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                drop_q, drop_d;
    logic                req_valid_d;
    logic [ADDR_W-1:0]   req_addr_d;
    logic                fetch_valid_d;
    logic [INST_LEN-1:0] inst_d;
    logic [ADDR_W-1:0]   fetch_pc_d;

    logic out_free;
    logic rsp_hit;

    assign out_free = ~fetch_valid_out | ~stall_dec_in;
    assign rsp_hit  = (state_q == S_WAIT) & imem_rsp_valid;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_REQ;
            pc_q             <= RESET_PC;
            drop_q           <= 1'b0;
            imem_req_valid   <= 1'b0;
            imem_req_addr    <= RESET_PC;
            fetch_valid_out  <= 1'b0;
            inst_fetched_out <= NOP_INST;
            fetch_pc_out     <= RESET_PC;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            drop_q           <= drop_d;
            imem_req_valid   <= req_valid_d;
            imem_req_addr    <= req_addr_d;
            fetch_valid_out  <= fetch_valid_d;
            inst_fetched_out <= inst_d;
            fetch_pc_out     <= fetch_pc_d;
        end
    end

    // Next state: a redirect never cancels the bus transaction in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:   if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // Next values of PC, drop flag, request and decode-facing output registers.
    always_comb begin
        pc_d          = pc_q;
        drop_d        = drop_q;
        req_valid_d   = imem_req_valid;
        req_addr_d    = imem_req_addr;
        fetch_valid_d = fetch_valid_out;
        inst_d        = inst_fetched_out;
        fetch_pc_d    = fetch_pc_out;

        if (fetch_valid_out && !stall_dec_in) begin
            fetch_valid_d = 1'b0;
            inst_d        = NOP_INST;
        end

        if (state_q == S_REQ) begin
            if (!imem_req_valid) begin
                if (out_free && !redirect_valid) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = pc_q;
                end
            end else if (imem_req_ready) begin
                req_valid_d = 1'b0;
            end
        end

        if (rsp_hit) begin
            if (drop_q) begin
                drop_d = 1'b0;
            end else if (!redirect_valid) begin
                fetch_valid_d = 1'b1;
                inst_d        = imem_rsp_data;
                fetch_pc_d    = pc_q;
                pc_d          = pc_q + ADDR_W'(4);
            end
        end

        // Redirect wins over every other PC/output update. Anything still owed by
        // memory after this edge belongs to the old path and must be dropped.
        if (redirect_valid) begin
            pc_d          = {redirect_pc[ADDR_W-1:2], 2'b00};
            fetch_valid_d = 1'b0;
            inst_d        = NOP_INST;
            if (imem_req_valid || ((state_q == S_WAIT) && !imem_rsp_valid)) begin
                drop_d = 1'b1;
            end
        end
    end

    rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        stall, redir;
    logic [31:0] redir_pc;
    logic [31:0] inst, fpc;
    logic        fvalid;

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (req_valid),
        .imem_req_ready   (req_ready),
        .imem_req_addr    (req_addr),
        .imem_rsp_valid   (rsp_valid),
        .imem_rsp_data    (rsp_data),
        .stall_dec_in     (stall),
        .redirect_valid   (redir),
        .redirect_pc      (redir_pc),
        .inst_fetched_out (inst),
        .fetch_valid_out  (fvalid),
        .fetch_pc_out     (fpc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs
    logic        d_rst = 1'b1, d_stall = 1'b0, d_redir = 1'b0;
    logic [31:0] d_rpc = 32'h0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: never
    int          lat_next = 0;     // extra response latency for the next accepted request

    // Memory: one outstanding request, returns its address as data
    logic        mem_pend = 1'b0;
    int          mem_delay = 0;
    logic [31:0] mem_addr = 32'h0;

    // Reference model: request slot, outstanding fetch, stale flag, decode slot
    logic        m_rv, m_out, m_stale, m_fv, m_loaded;
    logic [31:0] m_ra, m_inst, m_fpc, m_pc;
    logic [31:0] exp_stream, load_pc_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rv = 1'b0; m_ra = RESET_PC; m_out = 1'b0; m_stale = 1'b0;
        m_fv = 1'b0; m_inst = NOP; m_fpc = RESET_PC; m_pc = RESET_PC;
        exp_stream = RESET_PC;
    endtask

    task automatic model_step();
        logic        n_rv, n_out, n_stale, n_fv;
        logic [31:0] n_ra, n_inst, n_fpc, n_pc;
        m_loaded = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            n_rv = m_rv; n_ra = m_ra; n_out = m_out; n_stale = m_stale;
            n_fv = m_fv; n_inst = m_inst; n_fpc = m_fpc; n_pc = m_pc;
            if (m_fv && !stall) begin
                n_fv = 1'b0; n_inst = NOP;
            end
            if (!m_out) begin
                if (m_rv && req_ready) begin
                    n_rv = 1'b0; n_out = 1'b1;
                end else if (!m_rv && (!m_fv || !stall) && !redir) begin
                    n_rv = 1'b1; n_ra = m_pc;
                end
            end else if (rsp_valid) begin
                n_out = 1'b0;
                if (m_stale) begin
                    n_stale = 1'b0;
                end else if (!redir) begin
                    n_fv = 1'b1; n_inst = rsp_data; n_fpc = m_pc; n_pc = m_pc + 32'd4;
                    m_loaded = 1'b1;
                    load_pc_exp = exp_stream;
                    exp_stream = exp_stream + 32'd4;
                end
            end
            if (redir) begin
                n_pc = redir_pc & ~32'h3; n_fv = 1'b0; n_inst = NOP;
                if (m_rv || (m_out && !rsp_valid)) n_stale = 1'b1;
                exp_stream = n_pc;
            end
            m_rv = n_rv; m_ra = n_ra; m_out = n_out; m_stale = n_stale;
            m_fv = n_fv; m_inst = n_inst; m_fpc = n_fpc; m_pc = n_pc;
        end
    endtask

    task automatic mem_step(input logic s_rv, input logic [31:0] s_ra);
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (rsp_valid) mem_pend = 1'b0;
            else if (mem_pend && mem_delay > 0) mem_delay--;
            if (s_rv && req_ready) begin
                mem_pend = 1'b1; mem_delay = lat_next; mem_addr = s_ra;
            end
        end
    endtask

    task automatic compare_all();
        check("req_valid", 32'(req_valid), 32'(m_rv));
        check("req_addr", req_addr, m_ra);
        check("fetch_valid", 32'(fvalid), 32'(m_fv));
        check("inst", inst, m_inst);
        check("fetch_pc", fpc, m_fpc);
        if (m_loaded) begin
            check("stream_pc", fpc, load_pc_exp);
            check("stream_data", inst, fpc);
        end
    endtask

    // One clock cycle: drive inputs, advance model and memory at the edge, compare after.
    task automatic tick();
        logic        s_rv;
        logic [31:0] s_ra;
        rst      = d_rst;
        stall    = d_stall;
        redir    = d_redir;
        redir_pc = d_rpc;
        case (ready_mode)
            0:       req_ready = 1'b1;
            1:       req_ready = 1'($urandom_range(0, 1));
            default: req_ready = 1'b0;
        endcase
        rsp_valid = !d_rst && mem_pend && (mem_delay == 0);
        rsp_data  = rsp_valid ? mem_addr : 32'hDEAD_BEEF;
        s_rv = req_valid;
        s_ra = req_addr;
        @(posedge clk);
        model_step();
        mem_step(s_rv, s_ra);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_req_addr"}, req_addr, 32'h0000_1000);
        check({tag, "_fetch_valid"}, 32'(fvalid), 32'd0);
        check({tag, "_inst"}, inst, 32'h0000_0013);
        check({tag, "_fetch_pc"}, fpc, 32'h0000_1000);
    endtask

    initial begin
        // Reset
        d_rst = 1'b1;
        tick(); tick();
        check_reset_values("reset");

        // Zero-wait fetch of 0x1000
        d_rst = 1'b0;
        tick();
        check("first_req_valid", 32'(req_valid), 32'd1);
        check("first_req_addr", req_addr, 32'h0000_1000);
        tick();
        check("accept_clears_valid", 32'(req_valid), 32'd0);
        tick();
        check("out0_valid", 32'(fvalid), 32'd1);
        check("out0_pc", fpc, 32'h0000_1000);
        check("out0_inst", inst, 32'h0000_1000);
        tick();
        check("req1_addr", req_addr, 32'h0000_1004);
        check("consumed_inst_nop", inst, 32'h0000_0013);

        // Memory not ready for 3 cycles
        ready_mode = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_req_valid", 32'(req_valid), 32'd1);
            check("hold_req_addr", req_addr, 32'h0000_1004);
        end
        ready_mode = 0;
        tick(); tick();
        check("out1_pc", fpc, 32'h0000_1004);
        check("out1_inst", inst, 32'h0000_1004);

        // Decode stall with valid output
        d_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_req", 32'(req_valid), 32'd0);
            check("stall_valid", 32'(fvalid), 32'd1);
            check("stall_pc", fpc, 32'h0000_1004);
        end
        d_stall = 1'b0;
        lat_next = 2;
        tick();
        check("after_stall_req", req_addr, 32'h0000_1008);
        check("after_stall_req_valid", 32'(req_valid), 32'd1);

        // Redirect while waiting for a slow response
        tick();
        lat_next = 0;
        d_redir = 1'b1; d_rpc = 32'h0000_2002;
        tick();
        d_redir = 1'b0;
        check("redir_clears_valid", 32'(fvalid), 32'd0);
        tick();
        check("no_req_while_outstanding", 32'(req_valid), 32'd0);
        tick();
        check("stale_rsp_dropped", 32'(fvalid), 32'd0);
        tick();
        check("redir_req_valid", 32'(req_valid), 32'd1);
        check("redir_req_addr", req_addr, 32'h0000_2000);
        tick(); tick();
        check("redir_out_pc", fpc, 32'h0000_2000);
        check("redir_out_inst", inst, 32'h0000_2000);

        // Redirect in the same cycle as the response
        tick();
        check("req_2004", req_addr, 32'h0000_2004);
        tick();
        d_redir = 1'b1; d_rpc = 32'h0000_3000;
        tick();
        d_redir = 1'b0;
        check("same_cycle_discard", 32'(fvalid), 32'd0);
        tick();
        check("same_cycle_req_valid", 32'(req_valid), 32'd1);
        check("same_cycle_req_addr", req_addr, 32'h0000_3000);
        tick(); tick();
        check("same_cycle_out_pc", fpc, 32'h0000_3000);

        // Reset while waiting for a response
        tick();
        tick();
        d_rst = 1'b1;
        tick();
        check_reset_values("midreset");
        d_rst = 1'b0;
        tick();
        check("restart_req_addr", req_addr, 32'h0000_1000);
        tick(); tick();
        check("restart_out_pc", fpc, 32'h0000_1000);
        check("restart_out_valid", 32'(fvalid), 32'd1);

        // Randomized traffic against the model
        ready_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            d_rst    = ($urandom_range(0, 199) == 0);
            d_stall  = ($urandom_range(0, 99) < 30);
            d_redir  = ($urandom_range(0, 99) < 6);
            d_rpc    = $urandom;
            lat_next = $urandom_range(0, 3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
